id_issue_scoreboard: RTL
========================

Name: id_issue_scoreboard

Overview:
- Sits between the instruction decoder and the execute stage as the decode-stage issue controller.
- Holds one decoded instruction in a pipeline register and tracks pending register writes in a 32-entry scoreboard.
- Issues only when all source and destination registers are free, handling RAW and WAW hazards.
- Releases scoreboard entries on writeback and discards the held instruction on pipeline flush.

Parameters:
- REG_COUNT, 32, number of architectural integer registers; x0 is never marked busy.
- REG_ADDR_WIDTH, 5, register index width; equals log2(REG_COUNT).
- INSTRUCTION_WIDTH, 32, width of the raw instruction carried alongside the decoded fields.
- STALL_CNT_WIDTH, 16, width of the saturating hazard-stall counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  decoder presents a decoded instruction.
- in_ready  output  1  stage can accept this cycle.
- in_instr  input  INSTRUCTION_WIDTH  raw instruction word.
- in_rd / in_rs1 / in_rs2  input  REG_ADDR_WIDTH each  decoded register indices.
- in_uses_rs1 / in_uses_rs2 / in_writes_rd  input  1 each  operand-use flags (0 for rs2 on I/U/J formats, etc.).
- out_valid  output  1  held instruction is hazard-free and issuing.
- out_ready  input  1  execute stage accepts.
- out_instr  output  INSTRUCTION_WIDTH  held instruction.
- out_rd / out_rs1 / out_rs2  output  REG_ADDR_WIDTH each  held indices.
- out_writes_rd  output  1  held writes_rd flag.
- wb_valid  input  1  writeback retires a register write.
- wb_rd  input  REG_ADDR_WIDTH  register being written back.
- flush  input  1  discard the held instruction (branch/jump redirect).
- busy_vec  output  REG_COUNT  current scoreboard state.
- stall_cycles  output  STALL_CNT_WIDTH  count of cycles with held valid but blocked by a hazard.

Behaviour:
- State: EMPTY / FULL (1-bit held_valid) plus busy[REG_COUNT-1:0] and the stall counter.
- Reset (rst=1 at clk edge): held_valid=0, busy=0, stall_cycles=0. All out_* fields are 0, out_valid=0.
  - Reset mid-operation drops the held instruction and all pending busy bits.
- Effective busy: eff_busy = busy & ~(wb_valid ? onehot(wb_rd) : 0). The writeback clear is bypassed in the same cycle.
- Hazard: held_valid & ((uses_rs1 & rs1≠0 & eff_busy[rs1]) | (uses_rs2 & rs2≠0 & eff_busy[rs2]) | (writes_rd & rd≠0 & eff_busy[rd])).
- out_valid = held_valid & ~hazard & ~flush. Combinational; no outputs depend on in_valid.
- Issue fire = out_valid & out_ready.
- in_ready = ~held_valid | fire | flush. Single-entry register with no skid; throughput is 1 per cycle when there are no hazards.
- Accept = in_valid & in_ready. On accept, the held fields load in_* on the next edge and held_valid=1.
  - Fire and accept in the same cycle replace the held entry (back-to-back issue).
- EMPTY→FULL on accept.
- FULL→EMPTY on fire without accept, or flush without accept.
- FULL→FULL on stall, or on fire+accept.
- Flush: held entry invalidated; no issue that cycle. A same-cycle accept is allowed and loads the new (post-redirect) instruction. busy is not cleared by flush, because already-issued instructions still write back.
- Scoreboard update, next busy = (busy & ~wb_clear) | issue_set.
  - issue_set = onehot(out_rd) if fire & out_writes_rd & out_rd≠0.
  - On the same register, set wins over clear; the new writer's pending write persists.
  - wb_rd=0 has no effect. wb on a non-busy register has no effect and is not an error.
- busy[0] is always 0.
- stall_cycles increments by 1 each cycle with held_valid & hazard & ~flush, saturating at all-ones. It is cleared only by rst.
- Stalls caused by out_ready=0 without a hazard are not counted.
- Latency: an instruction accepted at edge N can issue in cycle N+1 at the earliest.

Test Plan:
- Reset then idle → out_valid=0, in_ready=1, busy_vec=0, stall_cycles=0.
- Issue ADD rd=5 (writes_rd=1), out_ready=1 → busy_vec[5]=1 next cycle. A following instr with rs1=5 holds out_valid=0 and stall_cycles increments each cycle. After wb_valid=1, wb_rd=5, it issues in that same cycle and busy_vec[5]=0.
- WAW: held instr rd=7 with busy[7]=1 → blocked. wb_rd=7 in the issue cycle → issues; busy_vec[7] stays 1 (set wins).
- Instr rd=0 writes_rd=1, and rs1=0 while busy is all zero → issues immediately; busy_vec stays 0.
- out_ready=0 for 3 cycles with a hazard-free held instr → out_valid=1 throughout, in_ready=0, stall_cycles unchanged. Then out_ready=1 with in_valid=1 → back-to-back issue at 1 per cycle.
- Held instr stalled on busy[3]; assert flush with in_valid=1 carrying rd=9 → old instr never issues, new instr is held, busy_vec[3] remains 1. Assert rst mid-stall → busy_vec=0, out_valid=0.

Source files
------------

// File: rtl/id_issue_scoreboard.sv
// id_issue_scoreboard
//
// Decode-stage issue controller. It holds one decoded instruction in a
// single-entry pipeline register and tracks pending register writes in a
// REG_COUNT-entry busy scoreboard. The held instruction issues only when none
// of its source or destination registers has a write outstanding, which
// covers RAW and WAW hazards. A writeback in the same cycle is bypassed
// through the scoreboard, so a stalled instruction can issue in the very
// cycle its blocking register retires.
//
// Ports
//   clk, rst            clock (rising edge) and synchronous active-high reset
//   in_valid/in_ready   decoder handshake
//   in_instr            raw instruction word carried alongside the fields
//   in_rd/rs1/rs2       decoded register indices
//   in_uses_rs1/rs2     source operand use flags
//   in_writes_rd        instruction writes rd
//   out_valid/out_ready execute-stage handshake
//   out_instr, out_rd/rs1/rs2, out_writes_rd   held instruction fields
//   wb_valid, wb_rd     writeback retiring a register write
//   flush               discard the held instruction (redirect)
//   busy_vec            current scoreboard contents
//   stall_cycles        saturating count of hazard-blocked cycles
module id_issue_scoreboard #(
  parameter int REG_COUNT         = 32,
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int STALL_CNT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INSTRUCTION_WIDTH-1:0] in_instr,
  input  logic [REG_ADDR_WIDTH-1:0]    in_rd,
  input  logic [REG_ADDR_WIDTH-1:0]    in_rs1,
  input  logic [REG_ADDR_WIDTH-1:0]    in_rs2,
  input  logic                         in_uses_rs1,
  input  logic                         in_uses_rs2,
  input  logic                         in_writes_rd,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INSTRUCTION_WIDTH-1:0] out_instr,
  output logic [REG_ADDR_WIDTH-1:0]    out_rd,
  output logic [REG_ADDR_WIDTH-1:0]    out_rs1,
  output logic [REG_ADDR_WIDTH-1:0]    out_rs2,
  output logic                         out_writes_rd,
  input  logic                         wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0]    wb_rd,
  input  logic                         flush,
  output logic [REG_COUNT-1:0]         busy_vec,
  output logic [STALL_CNT_WIDTH-1:0]   stall_cycles
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t                       state_q, state_d;
  logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d;
  logic [REG_ADDR_WIDTH-1:0]    rd_q, rd_d;
  logic [REG_ADDR_WIDTH-1:0]    rs1_q, rs1_d;
  logic [REG_ADDR_WIDTH-1:0]    rs2_q, rs2_d;
  logic                         uses_rs1_q, uses_rs1_d;
  logic                         uses_rs2_q, uses_rs2_d;
  logic                         writes_rd_q, writes_rd_d;
  logic [REG_COUNT-1:0]         busy_q, busy_d;
  logic [STALL_CNT_WIDTH-1:0]   stall_q, stall_d;

  logic                         held_valid;
  logic [REG_COUNT-1:0]         wb_clear;
  logic [REG_COUNT-1:0]         eff_busy;
  logic [REG_COUNT-1:0]         issue_set;
  logic                         rs1_hazard, rs2_hazard, rd_hazard;
  logic                         hazard;
  logic                         fire;
  logic                         accept;

  assign held_valid = (state_q == FULL);

  // Writeback clears are visible in the same cycle so a stalled consumer
  // can issue alongside the retiring write.
  always_comb begin
    wb_clear = '0;
    if (wb_valid) begin
      wb_clear[wb_rd] = 1'b1;
    end
  end

  assign eff_busy = busy_q & ~wb_clear;

  // x0 never carries a pending write, so it never blocks.
  assign rs1_hazard = uses_rs1_q  && (rs1_q != '0) && eff_busy[rs1_q];
  assign rs2_hazard = uses_rs2_q  && (rs2_q != '0) && eff_busy[rs2_q];
  assign rd_hazard  = writes_rd_q && (rd_q  != '0) && eff_busy[rd_q];
  assign hazard     = held_valid && (rs1_hazard || rs2_hazard || rd_hazard);

  assign out_valid = held_valid && !hazard && !flush;
  assign fire      = out_valid && out_ready;
  assign in_ready  = !held_valid || fire || flush;
  assign accept    = in_valid && in_ready;

  always_comb begin
    issue_set = '0;
    if (fire && writes_rd_q && (rd_q != '0)) begin
      issue_set[rd_q] = 1'b1;
    end
  end

  // Next-state logic. The issue set is OR-ed after the writeback clear so a
  // new writer to the retiring register keeps its pending bit. Flush never
  // touches the scoreboard because already-issued writes still retire.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    uses_rs1_d  = uses_rs1_q;
    uses_rs2_d  = uses_rs2_q;
    writes_rd_d = writes_rd_q;
    stall_d     = stall_q;

    if (accept) begin
      state_d     = FULL;
      instr_d     = in_instr;
      rd_d        = in_rd;
      rs1_d       = in_rs1;
      rs2_d       = in_rs2;
      uses_rs1_d  = in_uses_rs1;
      uses_rs2_d  = in_uses_rs2;
      writes_rd_d = in_writes_rd;
    end else if (fire || flush) begin
      state_d = EMPTY;
    end

    busy_d    = (busy_q & ~wb_clear) | issue_set;
    busy_d[0] = 1'b0;

    // Backpressure from out_ready alone is not a hazard and is not counted.
    if (hazard && !flush && (stall_q != '1)) begin
      stall_d = stall_q + {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      instr_q     <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      uses_rs1_q  <= 1'b0;
      uses_rs2_q  <= 1'b0;
      writes_rd_q <= 1'b0;
      busy_q      <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      uses_rs1_q  <= uses_rs1_d;
      uses_rs2_q  <= uses_rs2_d;
      writes_rd_q <= writes_rd_d;
      busy_q      <= busy_d;
      stall_q     <= stall_d;
    end
  end

  assign out_instr     = instr_q;
  assign out_rd        = rd_q;
  assign out_rs1       = rs1_q;
  assign out_rs2       = rs2_q;
  assign out_writes_rd = writes_rd_q;
  assign busy_vec      = busy_q;
  assign stall_cycles  = stall_q;

endmodule
